stch2dec_window: RTL
====================

Name: stch2dec_window

Overview:
Downstream consumer of the stochastic stream produced by the decimal-to-stochastic comparator stage. It counts ones in the bit stream S over a fixed window of 2^WIN_LOG2 sampled cycles. It then emits the ND-bit decimal estimate, scaled to x/2^ND, with a one-cycle valid strobe. It closes the DEC2STCH → SNN → readout loop, so network outputs can be read as probabilities.

Parameters:
ND, 8, output precision in bits; output scaled to x/2^ND, matching the converter's input format
WIN_LOG2, 8, log2 of window length in sampled cycles; must be ≥ ND (elaboration error otherwise)

Ports:
CLK  input  1  clock, rising edge
INIT  input  1  reset, synchronous, active-high
RUN  input  1  level; request accumulation windows (continuous while held)
EN  input  1  sample qualifier; S counted and window advanced only when EN=1
S  input  1  stochastic bit from upstream stage
D  output  ND  decimal estimate of last completed window; held until next completion
D_VALID  output  1  one-cycle pulse when D updates
BUSY  output  1  high while in ACCUM

Behaviour:
- Reset (INIT=1 at a CLK edge): state=IDLE, D=0, D_VALID=0, BUSY=0, ones counter=0, window counter=0. INIT overrides all other inputs.
- Internal ones counter: WIN_LOG2+1 bits. Window counter: WIN_LOG2 bits.
- State IDLE, BUSY=0:
  - RUN=1 → ACCUM next cycle; both counters cleared.
  - S is not sampled in the transition cycle.
- State ACCUM, BUSY=1, each cycle with EN=1:
  - ones += S; wcnt += 1.
  - EN=0: counters hold; stall for any length, no timeout.
- Window end: the cycle with EN=1 and wcnt=2^WIN_LOG2-1.
  - Final total T = ones + S, in the range 0..2^WIN_LOG2.
  - Next edge: D <= sat(T >> (WIN_LOG2-ND)), D_VALID <= 1.
  - sat: a value equal to 2^ND clamps to 2^ND-1, consistent with the converter's treatment of all-ones as probability 1.
  - Latency: D_VALID rises on the edge after the last sample.
- After window end:
  - RUN=1: stay in ACCUM; counters restart at 0 on the same edge. The next cycle's S is sample 0 of the new window, so back-to-back windows have no gap.
  - RUN=0: → IDLE.
- RUN deasserted mid-window: the current window completes normally, then → IDLE. No abort path other than INIT.
- D_VALID is high for exactly one cycle per completed window; otherwise 0.
- D is unchanged between completions, including across IDLE periods.
- INIT mid-window: window discarded, no D_VALID, D returns to 0.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package (stch_pkg):
  - state encoding IDLE/ACCUM (2 states, 1 bit)
  - function/constant for saturated max = 2^ND-1, shared with DEC2STCH's maxOut notion
  - WIN_LOG2 ≥ ND check macro
- One natural sub-module: stch_ones_counter, an EN-gated, synchronously-clearable (WIN_LOG2+1)-bit ones counter with terminal-count flag. The FSM, scaling and saturation stay in the top.

Test Plan:
- ND=8, WIN_LOG2=8, RUN=1, EN=1, S=1 for 256 samples → D_VALID once on the edge after sample 255, D=255 (saturated from 256).
- Same config, S alternating 1/0 for 256 samples → D=128. S=0 throughout → D=0, D_VALID still pulses.
- Same config, RUN held, 3 windows with 64/192/100 ones → D_VALID pulses exactly 256 cycles apart, D = 64, 192, 100; no dropped sample at boundaries.
- EN toggled 1/0 every cycle, 256 ones total → completion after 511 cycles, D=255. BUSY=1 throughout; S during EN=0 cycles (driven opposite) is ignored.
- WIN_LOG2=10, ND=8, 512 ones in 1024 samples → D=128; 1023 ones → D=255.
- RUN dropped at sample 100 → window still completes at sample 255, then IDLE and BUSY=0. A separate run with INIT at sample 100 → no D_VALID, D=0, IDLE next cycle.

Source files
------------

// File: rtl/stch_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : stch_pkg
//  Description : Shared types, constants and helpers for the stochastic
//                readout path (stochastic stream -> decimal estimate).
//  Revision    : 1.0  initial release
// ============================================================================
package stch_pkg;

  // Readout controller states: waiting for RUN, or accumulating a window.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } stch_state_e;

  // Largest representable estimate. An all-ones code stands for
  // probability 1, the same meaning the DEC2STCH converter gives maxOut.
  function automatic int unsigned stch_max_out(input int unsigned nd);
    return (32'd1 << nd) - 32'd1;
  endfunction

  // A window shorter than the output precision cannot fill every output bit.
  function automatic bit stch_win_ok(input int nd, input int win_log2);
    return (win_log2 >= nd);
  endfunction

endpackage

// Elaboration-time guard for the window/precision relationship; expands to a
// labelled generate-if that only elaborates in a bad configuration.
`ifndef STCH_CHECK_WIN
`define STCH_CHECK_WIN(ND_, WIN_) \
  if (!stch_pkg::stch_win_ok((ND_), (WIN_))) begin : g_win_check_fail \
    $error("stch: WIN_LOG2 must be >= ND"); \
  end
`endif
`default_nettype wire

// File: rtl/stch_ones_counter.sv
`default_nettype none
// ============================================================================
//  Module      : stch_ones_counter
//  Description : EN-gated ones counter for one accumulation window, with a
//                window-position counter, terminal-count flag and the
//                window total including the bit presented this cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module stch_ones_counter #(
  parameter int WIN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                s,
  output logic                tc,
  output logic [WIN_LOG2:0]   total
);

  logic [WIN_LOG2:0]   ones_q, ones_d;
  logic [WIN_LOG2-1:0] wcnt_q, wcnt_d;

  // Window position is at its last sample; the caller qualifies with EN.
  assign tc    = &wcnt_q;
  // Running total with the current bit folded in, so the final sample of a
  // window never needs its own extra cycle.
  assign total = ones_q + {{WIN_LOG2{1'b0}}, s};

  // Next-count: clear has priority, otherwise advance only on qualified samples.
  always_comb begin
    ones_d = ones_q;
    wcnt_d = wcnt_q;
    if (clr) begin
      ones_d = '0;
      wcnt_d = '0;
    end else if (en) begin
      ones_d = total;
      wcnt_d = wcnt_q + WIN_LOG2'(1);
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= '0;
      wcnt_q <= '0;
    end else begin
      ones_q <= ones_d;
      wcnt_q <= wcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stch2dec_window.sv
`default_nettype none
// ============================================================================
//  Module      : stch2dec_window
//  Description : Counts ones of a stochastic bit stream over a window of
//                2^WIN_LOG2 qualified samples and emits the saturated
//                ND-bit estimate (x/2^ND) with a one-cycle valid strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module stch2dec_window
  import stch_pkg::*;
#(
  parameter int ND       = 8,
  parameter int WIN_LOG2 = 8
) (
  input  logic          CLK,
  input  logic          INIT,
  input  logic          RUN,
  input  logic          EN,
  input  logic          S,
  output logic [ND-1:0] D,
  output logic          D_VALID,
  output logic          BUSY
);

  `STCH_CHECK_WIN(ND, WIN_LOG2)

  localparam int                SHIFT    = WIN_LOG2 - ND;
  localparam logic [ND-1:0]     MAX_OUT  = ND'(stch_max_out(ND));
  localparam logic [WIN_LOG2:0] MAX_WIDE = (WIN_LOG2 + 1)'(stch_max_out(ND));

  stch_state_e         state_q, state_d;
  logic [ND-1:0]       d_q, d_d;
  logic                d_valid_q, d_valid_d;
  logic                cnt_clr, cnt_en, cnt_tc;
  logic [WIN_LOG2:0]   total, shifted;
  logic [ND-1:0]       d_sat;

  stch_ones_counter #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_ones_counter (
    .clk   (CLK),
    .rst   (INIT),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .s     (S),
    .tc    (cnt_tc),
    .total (total)
  );

  // Scale the window total down to ND bits; only a full window of ones
  // (exactly 2^ND after scaling) overflows and is clamped to all-ones.
  assign shifted = total >> SHIFT;
  assign d_sat   = (shifted > MAX_WIDE) ? MAX_OUT : shifted[ND-1:0];

  // Next state, counter control and result capture.
  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    d_valid_d = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (RUN) begin
          state_d = ST_ACCUM;
          cnt_clr = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (EN) begin
          if (cnt_tc) begin
            // Last sample of the window: publish and restart so a held RUN
            // begins the next window on the very next sample.
            d_d       = d_sat;
            d_valid_d = 1'b1;
            cnt_clr   = 1'b1;
            if (!RUN) begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; INIT discards any window in progress.
  always_ff @(posedge CLK) begin
    if (INIT) begin
      state_q   <= ST_IDLE;
      d_q       <= '0;
      d_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign D       = d_q;
  assign D_VALID = d_valid_q;
  assign BUSY    = (state_q == ST_ACCUM);

endmodule
`default_nettype wire
